// File: rtl/move_encoder.sv
// Keypad-to-move encoder for the game controller.
// Converts nine raw cell buttons into one validated cell index (0..8, index 0 = cell 1).
// Keys are synchronised and debounced. Presses on occupied cells and multi-key presses
// are rejected. Each legal move is offered once over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   key_in[8:0]  raw asynchronous cell buttons, bit i = cell i+1
//   occupied[8:0] board occupancy, bit i set = cell i+1 taken
//   enable       game accepting moves (sampled in IDLE only)
//   move_ready   consumer accepts the offered move this cycle
//   move_valid   move_idx holds a legal move
//   move_idx[3:0] encoded cell index 0..8
//   err_occupied one-cycle pulse: pressed cell already occupied
//   err_multi    one-cycle pulse: more than one key in the debounced snapshot
//   busy         high whenever the encoder is not in IDLE
module move_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] key_in,
    input  logic [8:0] occupied,
    input  logic       enable,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_idx,
    output logic       err_occupied,
    output logic       err_multi,
    output logic       busy
);

    localparam int unsigned KEYS  = 9;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        OFFER    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [KEYS-1:0]  key_m, key_s;
    logic [KEYS-1:0]  snap, snap_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             valid_next, err_occ_next, err_multi_next, busy_next;
    logic [3:0]       idx_next;
    logic [3:0]       pop_c;
    logic [3:0]       idx_c;
    logic             occ_hit_c;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_m <= '0;
            key_s <= '0;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
        end
    end

    // Snapshot popcount, highest set bit index and occupancy hit
    always_comb begin
        pop_c     = '0;
        idx_c     = '0;
        occ_hit_c = |(snap & occupied);
        for (int i = 0; i < int'(KEYS); i++) begin
            if (snap[i]) begin
                pop_c = pop_c + 4'd1;
                idx_c = 4'(i);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            snap         <= '0;
            cnt          <= '0;
            move_valid   <= 1'b0;
            move_idx     <= '0;
            err_occupied <= 1'b0;
            err_multi    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            snap         <= snap_next;
            cnt          <= cnt_next;
            move_valid   <= valid_next;
            move_idx     <= idx_next;
            err_occupied <= err_occ_next;
            err_multi    <= err_multi_next;
            busy         <= busy_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        snap_next      = snap;
        cnt_next       = cnt;
        valid_next     = 1'b0;
        idx_next       = move_idx;
        err_occ_next   = 1'b0;
        err_multi_next = 1'b0;

        case (state)
            IDLE: begin
                if (enable && (key_s != '0)) begin
                    snap_next  = key_s;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_s == '0) begin
                    state_next = IDLE;
                end else if (key_s != snap) begin
                    snap_next = key_s;
                    cnt_next  = '0;
                end else if (cnt != CNT_LAST) begin
                    cnt_next = cnt + CNT_W'(1);
                end else begin
                    cnt_next = '0;
                    if (pop_c != 4'd1) begin
                        err_multi_next = 1'b1;
                        state_next     = RELEASE;
                    end else if (occ_hit_c) begin
                        err_occ_next = 1'b1;
                        state_next   = RELEASE;
                    end else begin
                        valid_next = 1'b1;
                        idx_next   = idx_c;
                        state_next = OFFER;
                    end
                end
            end
            OFFER: begin
                // Hold the move until the consumer takes it; inputs are ignored here
                if (move_ready) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end else begin
                    valid_next = 1'b1;
                end
            end
            RELEASE: begin
                // Any key activity restarts the all-released count
                if (key_s != '0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_move_encoder.sv
// Directed testbench for move_encoder with DEBOUNCE_CYCLES = 4.
module tb_move_encoder;

    logic       clk;
    logic       rst_n;
    logic [8:0] key_in;
    logic [8:0] occupied;
    logic       enable;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_idx;
    logic       err_occupied;
    logic       err_multi;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_eocc  = 0;
    int n_emul  = 0;
    int n_excl  = 0;
    int last_idx = -1;

    move_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .occupied    (occupied),
        .enable      (enable),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_idx    (move_idx),
        .err_occupied(err_occupied),
        .err_multi   (err_multi),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (move_valid && move_ready) begin
                n_xfer   = n_xfer + 1;
                last_idx = int'(move_idx);
            end
            if (err_occupied) n_eocc = n_eocc + 1;
            if (err_multi)    n_emul = n_emul + 1;
            if (int'(move_valid) + int'(err_occupied) + int'(err_multi) > 1)
                n_excl = n_excl + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick(1);
            if (move_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int lat;
        int xf, eo, em;

        rst_n      = 1'b0;
        key_in     = 9'h010;
        occupied   = 9'h000;
        enable     = 1'b1;
        move_ready = 1'b1;

        // Test 1: reset state, then latency with ready already high
        tick(2);
        check("t1_reset_outputs", 32'({move_valid, move_idx, err_occupied, err_multi, busy}), 32'd0);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick(1);
            if (move_valid) lat = k;
        end
        check("t1_latency", 32'(lat), 32'd7);
        check("t1_idx", 32'(move_idx), 32'd4);
        tick(1);
        check("t1_one_pulse", 32'(move_valid), 32'd0);
        key_in = 9'h000;
        tick(10);
        check("t1_xfer_count", 32'(n_xfer), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Test 2: backpressure, key dropped mid-offer
        move_ready = 1'b0;
        key_in     = 9'h100;
        wait_valid("t2_wait", 20);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold", 32'({move_valid, move_idx}), 32'h18);
            if (i == 4) key_in = 9'h000;
            tick(1);
        end
        move_ready = 1'b1;
        tick(1);
        check("t2_drop_after_ready", 32'(move_valid), 32'd0);
        move_ready = 1'b0;
        tick(15);
        check("t2_xfer_count", 32'(n_xfer), 32'd2);
        check("t2_xfer_idx", 32'(last_idx), 32'd8);

        // Test 3: bouncing key, then stable hold
        xf = n_xfer; eo = n_eocc; em = n_emul;
        for (int i = 0; i < 6; i++) begin
            key_in = (i % 2 == 0) ? 9'h004 : 9'h000;
            tick(2);
            check("t3_no_valid_bounce", 32'(move_valid), 32'd0);
        end
        check("t3_no_err_bounce", 32'(n_eocc + n_emul), 32'(eo + em));
        key_in = 9'h004;
        wait_valid("t3_wait", 20);
        check("t3_idx", 32'(move_idx), 32'd2);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        key_in = 9'h000;
        tick(10);
        check("t3_xfer_count", 32'(n_xfer), 32'(xf + 1));

        // Test 4: occupied cell, repress without a full release gap
        occupied = 9'h001;
        key_in   = 9'h001;
        tick(15);
        check("t4_err_occ", 32'(n_eocc), 32'(eo + 1));
        check("t4_no_xfer", 32'(n_xfer), 32'(xf + 1));
        key_in = 9'h000;
        tick(2);
        key_in = 9'h001;
        tick(15);
        check("t4_no_new_err", 32'(n_eocc), 32'(eo + 1));
        check("t4_no_valid", 32'(move_valid), 32'd0);
        key_in = 9'h000;
        tick(10);
        occupied = 9'h000;

        // Test 5: multi-key press, then legal single key
        key_in = 9'h003;
        tick(15);
        check("t5_err_multi", 32'(n_emul), 32'(em + 1));
        check("t5_no_xfer", 32'(n_xfer), 32'(xf + 1));
        key_in = 9'h000;
        tick(8);
        key_in = 9'h002;
        wait_valid("t5_wait", 20);
        check("t5_idx", 32'(move_idx), 32'd1);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        key_in = 9'h000;
        tick(10);
        check("t5_xfer_count", 32'(n_xfer), 32'(xf + 2));

        // Test 6: disabled game ignores keys; reset mid-offer drops the move
        enable = 1'b0;
        key_in = 9'h010;
        tick(10);
        check("t6_busy_disabled", 32'(busy), 32'd0);
        check("t6_no_valid_disabled", 32'(move_valid), 32'd0);
        enable = 1'b1;
        wait_valid("t6_wait", 20);
        rst_n  = 1'b0;
        key_in = 9'h000;
        tick(1);
        check("t6_reset_valid", 32'(move_valid), 32'd0);
        check("t6_reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(5);
        check("t6_stay_idle", 32'({move_valid, busy}), 32'd0);
        check("t6_xfer_count", 32'(n_xfer), 32'(xf + 2));

        check("exclusive_events", 32'(n_excl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
